// File: rtl/osc_pkg.sv
// -----------------------------------------------------------------------------
// osc_pkg
// Shared types and constants for the oscilloscope-style sample capture block.
//   SAMPLE_W        : width of one stored sample word (32 bits)
//   ST_*            : state encodings, kept as plain constants for older code
//   capture_state_t : capture state machine type, built on the ST_* encodings
//   sample_t        : one captured sample, {analog[1], analog[0], digital}
//   level_cross()   : edge/level trigger test on two 12-bit samples
// -----------------------------------------------------------------------------
package osc_pkg;

  localparam int SAMPLE_W = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_READ = 3'd4;

  typedef enum logic [2:0] {
    CAP_IDLE = ST_IDLE,
    CAP_PRE  = ST_PRE,
    CAP_WAIT = ST_WAIT,
    CAP_POST = ST_POST,
    CAP_READ = ST_READ
  } capture_state_t;

  // Analog channel 1 lands in the top bits, so the packed struct is already
  // the readout word layout.
  typedef struct packed {
    logic [1:0][11:0] analog;
    logic [7:0]       digital;
  } sample_t;

  // Rising: prev below the level and cur at or above it.
  // Falling: prev at or above the level and cur below it. Unsigned compares.
  function automatic logic level_cross(input logic        rising,
                                       input logic [11:0] level,
                                       input logic [11:0] prev,
                                       input logic [11:0] cur);
    if (rising) return (prev < level) && (cur >= level);
    else        return (prev >= level) && (cur < level);
  endfunction

endpackage

// File: rtl/sample_ram.sv
// -----------------------------------------------------------------------------
// sample_ram
// Simple dual-port capture buffer, DEPTH x SAMPLE_W, synchronous write and a
// one-cycle registered read. The read register only updates when re is high,
// so the caller can hold the output word by not re-reading.
//   clk   : clock, rising edge
//   we    : write enable,  waddr : write address,  wdata : write data
//   re    : read enable,   raddr : read address,   rdata : registered data
// -----------------------------------------------------------------------------
module sample_ram
  import osc_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Storage has no reset: contents are meaningless until a capture fills them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_capture.sv
// -----------------------------------------------------------------------------
// sample_capture
// Triggered capture of analog/digital samples into a circular buffer, with
// pre-trigger history, followed by a ready/valid readout of DEPTH words.
// Optional feature macro: SAMPLE_CAPTURE_FORCE_TRIG_EN adds the force_trig
// input, which triggers on the next written sample while waiting.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   sample_valid        : strobe qualifying analog_in / digital_in
//   analog_in[1:0]      : two 12-bit ADC channels;  digital_in : 8 lines
//   arm, abort          : start a capture / cancel anything in progress
//   trig_chan, trig_level, trig_rising, pretrig : trigger setup, latched at arm
//   force_trig          : (macro only) force a trigger while waiting
//   rd_data, rd_valid, rd_ready, rd_last : readout stream
//   busy                : not idle;  triggered : trigger seen this capture
// -----------------------------------------------------------------------------
module sample_capture
  import osc_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [1:0][11:0]      analog_in,
  input  logic [7:0]            digital_in,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_chan,
  input  logic [11:0]           trig_level,
  input  logic                  trig_rising,
  input  logic [ADDR_W-1:0]     pretrig,
`ifdef SAMPLE_CAPTURE_FORCE_TRIG_EN
  input  logic                  force_trig,
`endif
  output logic [SAMPLE_W-1:0]   rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  triggered
);

  localparam int CNT_W = ADDR_W + 1;

  capture_state_t      state;
  logic                trig_chan_q;
  logic                trig_rising_q;
  logic [11:0]         trig_level_q;
  logic [ADDR_W-1:0]   pretrig_q;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    rd_issued;
  logic [11:0]         prev;
  logic                have_prev;
  sample_t             wr_sample;
  logic [SAMPLE_W-1:0] ram_rdata;
  logic                wr_en;
  logic                level_hit;
  logic                trig_now;
  logic                rd_issue;
  logic [CNT_W-1:0]    post_len;

  assign wr_sample = {analog_in, digital_in};
  assign wr_en     = sample_valid && (state inside {CAP_PRE, CAP_WAIT, CAP_POST});
  assign post_len  = CNT_W'(DEPTH) - {1'b0, pretrig_q};
  assign busy      = (state != CAP_IDLE);

  // The very first written sample after arm has no predecessor and must not
  // trigger, hence the have_prev qualifier.
  assign level_hit = have_prev &&
                     level_cross(trig_rising_q, trig_level_q, prev,
                                 wr_sample.analog[trig_chan_q]);

`ifdef SAMPLE_CAPTURE_FORCE_TRIG_EN
  logic force_pend;

  // A force request may arrive on a cycle with no sample; remember it until
  // the next written sample in WAIT consumes it.
  always_ff @(posedge clk) begin
    if (reset || state != CAP_WAIT) force_pend <= 1'b0;
    else if (force_trig)            force_pend <= 1'b1;
  end

  assign trig_now = (state == CAP_WAIT) && wr_en &&
                    (level_hit || force_trig || force_pend);
`else
  assign trig_now = (state == CAP_WAIT) && wr_en && level_hit;
`endif

  // A new read is issued whenever the output word is empty or being taken,
  // which keeps one word per cycle with rd_ready high and freezes the RAM
  // output register during a stall.
  assign rd_issue = (state == CAP_READ) && (rd_issued != CNT_W'(DEPTH)) &&
                    (!rd_valid || rd_ready);

  // rd_data is zero whenever no word is presented, including after reset.
  assign rd_data = rd_valid ? ram_rdata : '0;

  sample_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_sample),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // Capture/readout state machine. Abort overrides everything except reset;
  // the sample bookkeeping at the bottom runs for every written sample in
  // PRE, WAIT and POST. rd_addr is loaded at the trigger with the oldest
  // pre-trigger address so READ can start issuing straight away.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CAP_IDLE;
      trig_chan_q   <= 1'b0;
      trig_rising_q <= 1'b0;
      trig_level_q  <= '0;
      pretrig_q     <= '0;
      wr_ptr        <= '0;
      rd_addr       <= '0;
      cnt           <= '0;
      rd_issued     <= '0;
      prev          <= '0;
      have_prev     <= 1'b0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      triggered     <= 1'b0;
    end else if (abort) begin
      state     <= CAP_IDLE;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      case (state)
        CAP_IDLE: begin
          if (arm) begin
            trig_chan_q   <= trig_chan;
            trig_rising_q <= trig_rising;
            trig_level_q  <= trig_level;
            pretrig_q     <= pretrig;
            wr_ptr        <= '0;
            cnt           <= '0;
            rd_issued     <= '0;
            prev          <= '0;
            have_prev     <= 1'b0;
            state         <= CAP_PRE;
          end
        end
        CAP_PRE: begin
          if (pretrig_q == '0) begin
            state <= CAP_WAIT;
          end else if (wr_en) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt + CNT_W'(1) == {1'b0, pretrig_q}) state <= CAP_WAIT;
          end
        end
        CAP_WAIT: begin
          if (trig_now) begin
            triggered <= 1'b1;
            rd_addr   <= wr_ptr - pretrig_q;
            cnt       <= CNT_W'(1);
            state     <= (post_len == CNT_W'(1)) ? CAP_READ : CAP_POST;
          end
        end
        CAP_POST: begin
          if (wr_en) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt + CNT_W'(1) == post_len) state <= CAP_READ;
          end
        end
        CAP_READ: begin
          if (rd_issue) begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            rd_issued <= rd_issued + CNT_W'(1);
            rd_valid  <= 1'b1;
            rd_last   <= (rd_issued == CNT_W'(DEPTH - 1));
          end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end
          if (rd_valid && rd_ready && rd_last) begin
            state     <= CAP_IDLE;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
          end
        end
        default: state <= CAP_IDLE;
      endcase

      if (wr_en) begin
        wr_ptr    <= wr_ptr + ADDR_W'(1);
        prev      <= wr_sample.analog[trig_chan_q];
        have_prev <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_sample_capture
// Directed bench for sample_capture at DEPTH=16. Every sample sent in a
// capture is recorded in order; the expected readout is the recorded sample
// sequence starting at a hand-worked index. Define SAMPLE_CAPTURE_FORCE_TRIG_EN
// to include the force_trig scenario.
// -----------------------------------------------------------------------------
module tb_sample_capture;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_valid;
  logic [1:0][11:0]  analog_in;
  logic [7:0]        digital_in;
  logic              arm;
  logic              abort;
  logic              trig_chan;
  logic [11:0]       trig_level;
  logic              trig_rising;
  logic [ADDR_W-1:0] pretrig;
`ifdef SAMPLE_CAPTURE_FORCE_TRIG_EN
  logic              force_trig;
`endif
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic              busy;
  logic              triggered;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] sent[$];

  always #5 clk = ~clk;

  sample_capture #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .analog_in    (analog_in),
    .digital_in   (digital_in),
    .arm          (arm),
    .abort        (abort),
    .trig_chan    (trig_chan),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .pretrig      (pretrig),
`ifdef SAMPLE_CAPTURE_FORCE_TRIG_EN
    .force_trig   (force_trig),
`endif
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_last      (rd_last),
    .busy         (busy),
    .triggered    (triggered)
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample for one cycle; the sample is recorded as its readout word.
  task automatic applyStimulus(input logic [11:0] a0, input logic [11:0] a1,
                               input logic [7:0] dig);
    analog_in[0] = a0;
    analog_in[1] = a1;
    digital_in   = dig;
    sample_valid = 1'b1;
    sent.push_back({a1, a0, dig});
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic armCapture(input logic chan, input logic [11:0] level,
                            input logic rising, input logic [ADDR_W-1:0] pre);
    trig_chan   = chan;
    trig_level  = level;
    trig_rising = rising;
    pretrig     = pre;
    arm         = 1'b1;
    sent.delete();
    tick();
    arm         = 1'b0;
  endtask

  // Drains DEPTH words, expecting sent[start..start+DEPTH-1]. With stall set,
  // rd_ready follows 1,0,0,1 and the held word is checked across stalls.
  task automatic readOut(input string name, input int start, input bit stall);
    int got = 0;
    int cyc = 0;
    bit holding = 1'b0;
    logic [31:0] held_data = '0;
    logic held_last = 1'b0;
    while (got < DEPTH && cyc < 400) begin
      rd_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (holding) begin
        checkOutput({name, "_stall_valid"}, 32'(rd_valid), 32'd1);
        checkOutput({name, "_stall_data"}, rd_data, held_data);
        checkOutput({name, "_stall_last"}, 32'(rd_last), 32'(held_last));
        holding = 1'b0;
      end
      if (rd_valid) begin
        if (rd_ready) begin
          checkOutput({name, "_data"}, rd_data, sent[start + got]);
          checkOutput({name, "_last"}, 32'(rd_last), 32'(got == DEPTH - 1));
          got++;
        end else begin
          held_data = rd_data;
          held_last = rd_last;
          holding   = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    checkOutput({name, "_count"}, 32'(got), 32'(DEPTH));
    checkOutput({name, "_end_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_end_trig"}, 32'(triggered), 32'd0);
    checkOutput({name, "_end_valid"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; sample_valid = 1'b0; analog_in = '0; digital_in = '0;
    arm = 1'b0; abort = 1'b0; trig_chan = 1'b0; trig_level = '0;
    trig_rising = 1'b0; pretrig = '0; rd_ready = 1'b0;
`ifdef SAMPLE_CAPTURE_FORCE_TRIG_EN
    force_trig = 1'b0;
`endif
    tick();
    tick();
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_trig",  32'(triggered), 32'd0);
    checkOutput("rst_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_last",  32'(rd_last), 32'd0);
    checkOutput("rst_data",  rd_data, 32'd0);
    reset = 1'b0;
    tick();

    // Ramp on ch0 in steps of 10, pretrig 4, rising at 100. Trigger is the
    // sample 100 (index 10); readout starts at 60 (index 6) through 210.
    armCapture(1'b0, 12'd100, 1'b1, 4'd4);
    checkOutput("t1_pre_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 22; k++) begin
      applyStimulus(12'(10 * k), 12'(2000 + k), 8'(k));
      if (k == 9)  checkOutput("t1_trig_before", 32'(triggered), 32'd0);
      if (k == 10) checkOutput("t1_trig_at", 32'(triggered), 32'd1);
    end
    readOut("t1", 6, 1'b0);

    // Falling at 50 on ch1 held at 20: never triggers; abort returns to idle.
    armCapture(1'b1, 12'd50, 1'b0, 4'd4);
    for (int k = 0; k < 10; k++) applyStimulus(12'(5 * k), 12'd20, 8'(k));
    checkOutput("t2_wait_busy", 32'(busy), 32'd1);
    checkOutput("t2_wait_trig", 32'(triggered), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t2_abort_busy", 32'(busy), 32'd0);
    checkOutput("t2_abort_valid", 32'(rd_valid), 32'd0);

    // pretrig 0: trigger on the second sample, which is the first word out.
    armCapture(1'b0, 12'd100, 1'b1, 4'd0);
    tick();
    applyStimulus(12'd50, 12'd1, 8'hA0);
    checkOutput("t3_trig_s1", 32'(triggered), 32'd0);
    applyStimulus(12'd150, 12'd2, 8'hA1);
    checkOutput("t3_trig_s2", 32'(triggered), 32'd1);
    for (int k = 1; k < 16; k++) applyStimulus(12'(150 + k), 12'(k), 8'(k));
    readOut("t3", 1, 1'b0);

    // ch1 ramp by 30, pretrig 2, rising at 100: trigger at 120 (index 4),
    // readout from index 2, read with a 1,0,0,1 ready pattern.
    armCapture(1'b1, 12'd100, 1'b1, 4'd2);
    for (int k = 0; k < 18; k++) applyStimulus(12'(k), 12'(30 * k), 8'(k + 100));
    readOut("t4", 2, 1'b1);

    // First sample after arm already above the level must not trigger.
    armCapture(1'b0, 12'd100, 1'b1, 4'd0);
    tick();
    applyStimulus(12'd200, 12'd0, 8'd1);
    checkOutput("t5_first_guard", 32'(triggered), 32'd0);
    applyStimulus(12'd50, 12'd0, 8'd2);
    checkOutput("t5_no_edge", 32'(triggered), 32'd0);
    applyStimulus(12'd150, 12'd0, 8'd3);
    checkOutput("t5_edge", 32'(triggered), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t5_abort_busy", 32'(busy), 32'd0);
    checkOutput("t5_abort_trig", 32'(triggered), 32'd0);

    // Reset in the middle of POST, then a clean re-capture.
    armCapture(1'b0, 12'd100, 1'b1, 4'd4);
    for (int k = 0; k < 14; k++) applyStimulus(12'(10 * k), 12'd7, 8'(k));
    checkOutput("t6_post_trig", 32'(triggered), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("t6_rst_busy",  32'(busy), 32'd0);
    checkOutput("t6_rst_trig",  32'(triggered), 32'd0);
    checkOutput("t6_rst_valid", 32'(rd_valid), 32'd0);
    checkOutput("t6_rst_last",  32'(rd_last), 32'd0);
    checkOutput("t6_rst_data",  rd_data, 32'd0);
    reset = 1'b0;
    tick();
    armCapture(1'b0, 12'd100, 1'b1, 4'd4);
    for (int k = 0; k < 22; k++) applyStimulus(12'(10 * k), 12'(3000 + k), 8'(k + 50));
    readOut("t6", 6, 1'b0);

`ifdef SAMPLE_CAPTURE_FORCE_TRIG_EN
    // Flat signal never crosses 4000; force in WAIT triggers on index 6.
    armCapture(1'b0, 12'd4000, 1'b1, 4'd4);
    for (int k = 0; k < 6; k++) applyStimulus(12'd7, 12'd7, 8'(k));
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    tick();
    checkOutput("t7_trig_before", 32'(triggered), 32'd0);
    for (int k = 6; k < 18; k++) begin
      applyStimulus(12'd7, 12'd7, 8'(k));
      if (k == 6) checkOutput("t7_trig_at", 32'(triggered), 32'd1);
    end
    readOut("t7", 2, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
